volume_gain_sequencer: RTL and testbench

//  Per-sample scheduler for the stereo gain datapath. One shared log-volume ROM and one
//  17x16 multiplier are time-multiplexed across channels 0 and 1 on each 48 kHz sample strobe.

---
 rtl/volume_gain_sequencer.sv | 151 +++++++++++++++
 tb/tb_volume_gain_sequencer.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/volume_gain_sequencer.sv
// Per-sample scheduler for the stereo gain path: one shared log-volume ROM and one 17x16
// multiplier serve both channels in turn; each channel's volume index slews one step per sample.
module volume_gain_sequencer #(
    parameter int ROM_LATENCY = 1
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               Sample_Ena,
    input  logic signed [15:0] Audio_In_0,
    input  logic signed [15:0] Audio_In_1,
    input  logic [7:0]         Volume_0,
    input  logic [7:0]         Volume_1,
    input  logic               Mute,
    output logic [7:0]         Rom_Address,
    input  logic [15:0]        Rom_Data,
    output logic [31:0]        Audio_Out_0,
    output logic [31:0]        Audio_Out_1,
    output logic               Out_Valid,
    output logic               Busy,
    output logic               Overrun,
    output logic [3:0]         Dbg_State,
    output logic [7:0]         Dbg_Cur_0,
    output logic [7:0]         Dbg_Cur_1
);

    // Handshake: Sample_Ena is a one-cycle strobe taken only in S_IDLE (no backpressure);
    // Out_Valid is a one-cycle strobe with both Audio_Out_* stable from that cycle on.
    typedef enum logic [3:0] {
        S_IDLE, S_A0, S_W0, S_M0, S_S0, S_A1, S_W1, S_M1, S_S1, S_DONE
    } state_t;

    localparam logic [1:0] WAIT_INIT = 2'(ROM_LATENCY - 1);

    state_t             state;
    logic [1:0]         wait_cnt;
    logic signed [15:0] snap_a0, snap_a1;
    logic [7:0]         snap_v0, snap_v1;
    logic               snap_mute;
    logic [7:0]         cur_0, cur_1;
    logic [31:0]        prod, res_0;

    logic [16:0]        abs_sel;
    logic [31:0]        prod_full;
    logic               sign_sel;
    logic [7:0]         cur_sel;
    logic [31:0]        scaled;

    // Magnitude needs 17 bits so that -32768 maps to +32768.
    function automatic logic [16:0] abs17(input logic signed [15:0] x);
        return x[15] ? (~{1'b1, x}) + 17'd1 : {1'b0, x};
    endfunction

    function automatic logic [7:0] ramp_step(input logic [7:0] cur, input logic [7:0] tgt);
        if (cur < tgt)      return cur + 8'd1;
        else if (cur > tgt) return cur - 8'd1;
        else                return cur;
    endfunction

    assign abs_sel   = (state == S_M1) ? abs17(snap_a1) : abs17(snap_a0);
    assign prod_full = 32'(abs_sel) * 32'(Rom_Data);
    assign sign_sel  = (state == S_S1) ? snap_a1[15] : snap_a0[15];
    assign cur_sel   = (state == S_S1) ? cur_1 : cur_0;
    // A muted channel sitting at index 0 is silent whatever ROM[0] holds.
    assign scaled    = (snap_mute && cur_sel == 8'd0) ? 32'd0 :
                       sign_sel ? 32'd0 - prod : prod;

    assign Dbg_State = state;
    assign Dbg_Cur_0 = cur_0;
    assign Dbg_Cur_1 = cur_1;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state       <= S_IDLE;
            wait_cnt    <= 2'd0;
            snap_a0     <= '0;
            snap_a1     <= '0;
            snap_v0     <= '0;
            snap_v1     <= '0;
            snap_mute   <= 1'b0;
            cur_0       <= '0;
            cur_1       <= '0;
            prod        <= '0;
            res_0       <= '0;
            Rom_Address <= '0;
            Audio_Out_0 <= '0;
            Audio_Out_1 <= '0;
            Out_Valid   <= 1'b0;
            Busy        <= 1'b0;
            Overrun     <= 1'b0;
        end else begin
            Out_Valid <= 1'b0;
            if (Sample_Ena && state != S_IDLE) Overrun <= 1'b1;
            case (state)
                S_IDLE: if (Sample_Ena) begin
                    snap_a0   <= Audio_In_0;
                    snap_a1   <= Audio_In_1;
                    snap_v0   <= Volume_0;
                    snap_v1   <= Volume_1;
                    snap_mute <= Mute;
                    Busy      <= 1'b1;
                    state     <= S_A0;
                end
                S_A0: begin
                    Rom_Address <= cur_0;
                    wait_cnt    <= WAIT_INIT;
                    state       <= S_W0;
                end
                S_W0: begin
                    if (wait_cnt == 2'd0) state <= S_M0;
                    else                  wait_cnt <= wait_cnt - 2'd1;
                end
                S_M0: begin
                    prod  <= prod_full;
                    state <= S_S0;
                end
                S_S0: begin
                    res_0 <= scaled;
                    state <= S_A1;
                end
                S_A1: begin
                    Rom_Address <= cur_1;
                    wait_cnt    <= WAIT_INIT;
                    state       <= S_W1;
                end
                S_W1: begin
                    if (wait_cnt == 2'd0) state <= S_M1;
                    else                  wait_cnt <= wait_cnt - 2'd1;
                end
                S_M1: begin
                    prod  <= prod_full;
                    state <= S_S1;
                end
                // Both outputs load together so they are valid during the DONE cycle.
                S_S1: begin
                    Audio_Out_0 <= res_0;
                    Audio_Out_1 <= scaled;
                    Out_Valid   <= 1'b1;
                    state       <= S_DONE;
                end
                S_DONE: begin
                    cur_0 <= ramp_step(cur_0, snap_mute ? 8'd0 : snap_v0);
                    cur_1 <= ramp_step(cur_1, snap_mute ? 8'd0 : snap_v1);
                    Busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_volume_gain_sequencer.sv
// Scoreboard bench for volume_gain_sequencer: two instances (ROM latency 1 and 2) with
// behavioural ROMs; stimulus pushes expected outputs, a negedge monitor pops and compares.
module tb_volume_gain_sequencer;

    logic clk = 1'b0;
    always #10 clk = ~clk;

    logic               reset, sample_ena, sample_ena2, mute;
    logic signed [15:0] audio_0, audio_1;
    logic [7:0]         vol_0, vol_1;
    logic [7:0]         rom_addr, rom_addr2;
    logic [15:0]        rom_data, rom_data2, rom_p2;
    logic [31:0]        out_0, out_1, out2_0, out2_1;
    logic               out_valid, busy, overrun, out_valid2, busy2, overrun2;
    logic [3:0]         dbg_state, dbg_state2;
    logic [7:0]         dbg_cur_0, dbg_cur_1, dbg2_cur_0, dbg2_cur_1;

    volume_gain_sequencer #(.ROM_LATENCY(1)) dut (
        .Clk(clk), .Reset(reset), .Sample_Ena(sample_ena),
        .Audio_In_0(audio_0), .Audio_In_1(audio_1), .Volume_0(vol_0), .Volume_1(vol_1),
        .Mute(mute), .Rom_Address(rom_addr), .Rom_Data(rom_data),
        .Audio_Out_0(out_0), .Audio_Out_1(out_1), .Out_Valid(out_valid), .Busy(busy),
        .Overrun(overrun), .Dbg_State(dbg_state), .Dbg_Cur_0(dbg_cur_0), .Dbg_Cur_1(dbg_cur_1)
    );

    volume_gain_sequencer #(.ROM_LATENCY(2)) dut2 (
        .Clk(clk), .Reset(reset), .Sample_Ena(sample_ena2),
        .Audio_In_0(audio_0), .Audio_In_1(audio_1), .Volume_0(vol_0), .Volume_1(vol_1),
        .Mute(mute), .Rom_Address(rom_addr2), .Rom_Data(rom_data2),
        .Audio_Out_0(out2_0), .Audio_Out_1(out2_1), .Out_Valid(out_valid2), .Busy(busy2),
        .Overrun(overrun2), .Dbg_State(dbg_state2), .Dbg_Cur_0(dbg2_cur_0), .Dbg_Cur_1(dbg2_cur_1)
    );

    // ROM contents: gain = idx*256, except ROM[255] = 0xFFFF and ROM[0] = rom0 (adjustable).
    logic [15:0] rom0 = 16'h0000;
    function automatic logic [15:0] rom_fn(input logic [7:0] idx);
        if (idx == 8'd255) return 16'hFFFF;
        if (idx == 8'd0)   return rom0;
        return {idx, 8'h00};
    endfunction

    always @(posedge clk) begin
        rom_data  <= rom_fn(rom_addr);
        rom_p2    <= rom_fn(rom_addr2);
        rom_data2 <= rom_p2;
    end

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0] exp_q0[$], exp_q1[$], exp_t[$];
    logic [31:0] exp2_q0[$], exp2_q1[$], exp2_t[$];
    logic [7:0]  m_cur0 = 8'd0, m_cur1 = 8'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model(input logic [15:0] a, input logic [7:0] c, input logic m);
        if (m && c == 8'd0) return 32'd0;
        return 32'(longint'($signed(a)) * longint'(rom_fn(c)));
    endfunction

    function automatic logic [7:0] m_step(input logic [7:0] c, input logic [7:0] t);
        if (c < t) return c + 8'd1;
        if (c > t) return c - 8'd1;
        return c;
    endfunction

    // Monitor: every Out_Valid must match the oldest outstanding expectation.
    always @(negedge clk) begin
        logic [31:0] e0, e1, et;
        if (out_valid) begin
            if (exp_q0.size() == 0) begin
                checks++; errors++;
                $display("FAIL spurious_valid: got Out_Valid=1 expected none (t=%0t)", $time);
            end else begin
                e0 = exp_q0.pop_front(); e1 = exp_q1.pop_front(); et = exp_t.pop_front();
                check("out_0", out_0, e0);
                check("out_1", out_1, e1);
                check("latency", 32'(cyc) - et, 32'd9);
            end
        end
        if (out_valid2) begin
            if (exp2_q0.size() == 0) begin
                checks++; errors++;
                $display("FAIL spurious_valid2: got Out_Valid=1 expected none (t=%0t)", $time);
            end else begin
                e0 = exp2_q0.pop_front(); e1 = exp2_q1.pop_front(); et = exp2_t.pop_front();
                check("out2_0", out2_0, e0);
                check("out2_1", out2_1, e1);
                check("latency2", 32'(cyc) - et, 32'd11);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Issue one accepted sample; inputs are scrambled right after to prove they were snapshotted.
    task automatic send(input logic [15:0] a0, input logic [15:0] a1, input logic [7:0] v0,
                        input logic [7:0] v1, input logic m, input bit hand,
                        input logic [31:0] h0, input logic [31:0] h1);
        audio_0 = a0; audio_1 = a1; vol_0 = v0; vol_1 = v1; mute = m;
        sample_ena = 1'b1;
        exp_q0.push_back(hand ? h0 : model(a0, m_cur0, m));
        exp_q1.push_back(hand ? h1 : model(a1, m_cur1, m));
        exp_t.push_back(32'(cyc));
        m_cur0 = m_step(m_cur0, m ? 8'd0 : v0);
        m_cur1 = m_step(m_cur1, m ? 8'd0 : v1);
        tick(1);
        sample_ena = 1'b0;
        audio_0 = 16'($urandom); audio_1 = 16'($urandom);
        vol_0 = 8'($urandom); vol_1 = 8'($urandom); mute = 1'($urandom_range(0, 1));
    endtask

    task automatic send_model(input logic [15:0] a0, input logic [15:0] a1, input logic [7:0] v,
                              input logic m, input int period);
        send(a0, a1, v, v, m, 1'b0, 32'd0, 32'd0);
        tick(period - 1);
    endtask

    initial begin
        reset = 1'b1; sample_ena = 1'b0; sample_ena2 = 1'b0; mute = 1'b0;
        audio_0 = '0; audio_1 = '0; vol_0 = '0; vol_1 = '0;
        tick(3);
        reset = 1'b0;
        @(negedge clk);
        check("rst_out_0", out_0, 32'd0);
        check("rst_out_1", out_1, 32'd0);
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_overrun", {31'd0, overrun}, 32'd0);
        check("rst_rom_addr", {24'd0, rom_addr}, 32'd0);
        check("rst_cur_0", {24'd0, dbg_cur_0}, 32'd0);
        check("rst_state", {28'd0, dbg_state}, 32'd0);
        tick(1);

        // Ramp 0..3 then hold: gain idx*256 on 0x4000 gives idx*0x400000.
        send(16'h4000, 16'h4000, 8'd3, 8'd3, 1'b0, 1'b1, 32'h0000_0000, 32'h0000_0000); tick(63);
        send(16'h4000, 16'h4000, 8'd3, 8'd3, 1'b0, 1'b1, 32'h0040_0000, 32'h0040_0000); tick(63);
        send(16'h4000, 16'h4000, 8'd3, 8'd3, 1'b0, 1'b1, 32'h0080_0000, 32'h0080_0000); tick(63);
        send(16'h4000, 16'h4000, 8'd3, 8'd3, 1'b0, 1'b1, 32'h00C0_0000, 32'h00C0_0000); tick(63);
        send(16'h4000, 16'h4000, 8'd3, 8'd3, 1'b0, 1'b1, 32'h00C0_0000, 32'h00C0_0000); tick(63);
        check("hold_cur_0", {24'd0, dbg_cur_0}, 32'd3);

        // Second strobe 4 cycles after the first is dropped and flags Overrun.
        send(16'h4000, 16'h4000, 8'd3, 8'd3, 1'b0, 1'b1, 32'h00C0_0000, 32'h00C0_0000);
        tick(3);
        audio_0 = 16'h1234; vol_0 = 8'd0; sample_ena = 1'b1;
        @(negedge clk);
        check("ovr_before", {31'd0, overrun}, 32'd0);
        tick(1);
        sample_ena = 1'b0;
        @(negedge clk);
        check("ovr_after", {31'd0, overrun}, 32'd1);
        check("ovr_busy", {31'd0, busy}, 32'd1);
        tick(12);

        // Reset five cycles into a sequence: no output, everything cleared.
        audio_0 = 16'h4000; audio_1 = 16'h4000; vol_0 = 8'd3; vol_1 = 8'd3; mute = 1'b0;
        sample_ena = 1'b1;
        tick(1);
        sample_ena = 1'b0;
        tick(4);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        m_cur0 = 8'd0; m_cur1 = 8'd0;
        tick(12);
        @(negedge clk);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_out_0", out_0, 32'd0);
        check("abort_out_1", out_1, 32'd0);
        check("abort_cur_0", {24'd0, dbg_cur_0}, 32'd0);
        check("abort_cur_1", {24'd0, dbg_cur_1}, 32'd0);
        check("abort_overrun", {31'd0, overrun}, 32'd0);
        tick(1);

        // Mute ramp with a nonzero ROM[0] so the forced-zero path is visible.
        rom0 = 16'h0123;
        for (int i = 0; i < 10; i++) send_model(16'h4000, 16'hE000, 8'd10, 1'b0, 12);
        check("up_cur_0", {24'd0, dbg_cur_0}, 32'd10);
        for (int i = 0; i < 10; i++) send_model(16'h4000, 16'hE000, 8'd10, 1'b1, 12);
        check("mute_cur_0", {24'd0, dbg_cur_0}, 32'd0);
        send(16'h4000, 16'hE000, 8'd10, 8'd10, 1'b1, 1'b1, 32'd0, 32'd0); tick(11);
        send(16'h7FFF, 16'h8000, 8'd10, 8'd10, 1'b1, 1'b1, 32'd0, 32'd0); tick(11);
        // Unmuted at index 0: 0x4000 * 0x0123 = 0x48C000.
        send(16'h4000, 16'h4000, 8'd10, 8'd10, 1'b0, 1'b1, 32'h0048_C000, 32'h0048_C000); tick(11);
        for (int i = 0; i < 9; i++) send_model(16'h4000, 16'hE000, 8'd10, 1'b0, 12);
        check("unmute_cur_1", {24'd0, dbg_cur_1}, 32'd10);

        // Full-scale extremes at index 255 (gain 0xFFFF).
        for (int i = 0; i < 245; i++) send_model(16'h4000, 16'hE000, 8'd255, 1'b0, 12);
        check("top_cur_0", {24'd0, dbg_cur_0}, 32'd255);
        // -32768*65535 = -2147450880 = 0x80008000; 32767*65535 = 2147385345 = 0x7FFE8001.
        send(16'h8000, 16'h7FFF, 8'd255, 8'd255, 1'b0, 1'b1, 32'h8000_8000, 32'h7FFE_8001);
        tick(11);
        send(16'h8000, 16'h7FFF, 8'd255, 8'd255, 1'b0, 1'b1, 32'h8000_8000, 32'h7FFE_8001);
        tick(11);
        check("sat_cur_1", {24'd0, dbg_cur_1}, 32'd255);

        // ROM latency 2 instance: 11-cycle latency; strobe in DONE is dropped.
        audio_0 = 16'h4000; audio_1 = 16'hC000; vol_0 = 8'd0; vol_1 = 8'd0; mute = 1'b0;
        sample_ena2 = 1'b1;
        exp2_q0.push_back(32'h0048_C000);
        exp2_q1.push_back(32'hFFB7_4000);
        exp2_t.push_back(32'(cyc));
        tick(1);
        sample_ena2 = 1'b0;
        tick(10);
        sample_ena2 = 1'b1;
        @(negedge clk);
        check("l2_done_valid", {31'd0, out_valid2}, 32'd1);
        check("l2_done_busy", {31'd0, busy2}, 32'd1);
        check("l2_ovr_before", {31'd0, overrun2}, 32'd0);
        tick(1);
        sample_ena2 = 1'b0;
        @(negedge clk);
        check("l2_ovr_after", {31'd0, overrun2}, 32'd1);
        check("l2_idle_busy", {31'd0, busy2}, 32'd0);
        tick(20);

        check("pending_dut", 32'(exp_q0.size()), 32'd0);
        check("pending_dut2", 32'(exp2_q0.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
